// File: rtl/reggp_wb.sv
// Writeback merge stage feeding the GP register file write port: execute results
// go straight through, load results queue in a small FIFO, one registered write per cycle.
module reggp_wb #(
    parameter int DATA_W     = 24,
    parameter int TGT_W      = 4,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_exe_valid,
    output logic              ow_exe_ready,
    input  logic [TGT_W-1:0]  iw_exe_tgt,
    input  logic [DATA_W-1:0] iw_exe_data,
    input  logic              iw_ld_valid,
    output logic              ow_ld_ready,
    input  logic [TGT_W-1:0]  iw_ld_tgt,
    input  logic [DATA_W-1:0] iw_ld_data,
    output logic              ow_write_enable,
    output logic [TGT_W-1:0]  ow_write_addr,
    output logic [DATA_W-1:0] ow_write_data,
    input  logic [TGT_W-1:0]  iw_read_addr1,
    input  logic [TGT_W-1:0]  iw_read_addr2,
    output logic              ow_fwd_valid1,
    output logic              ow_fwd_valid2,
    output logic [DATA_W-1:0] ow_fwd_data1,
    output logic [DATA_W-1:0] ow_fwd_data2,
    output logic              ow_pending1,
    output logic              ow_pending2
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // both ready outputs come from registered state only, never from valid.

    logic [TGT_W-1:0]  fifo_tgt  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic [SW-1:0]     starve;

    logic              fifo_empty;
    logic              fifo_full;
    logic              exe_fire;
    logic              ld_fire;
    logic              pop;

    logic [AW-1:0]     slot_off   [DEPTH];
    logic [DEPTH-1:0]  slot_valid;
    logic              pend1;
    logic              pend2;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == (AW+1)'(DEPTH));
    assign ow_ld_ready  = !fifo_full;
    assign ow_exe_ready = !((starve == SW'(STARVE_MAX)) && !fifo_empty);

    assign exe_fire = iw_exe_valid && ow_exe_ready;
    assign ld_fire  = iw_ld_valid && ow_ld_ready;
    // Execute always wins when it fires; the FIFO drains only in cycles exe leaves idle.
    assign pop      = !exe_fire && !fifo_empty;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i]   = AW'(i) - rd_ptr;
            slot_valid[i] = ({1'b0, slot_off[i]} < count);
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (fifo_tgt[i] == iw_read_addr1)) begin
                pend1 = 1'b1;
            end
            if (slot_valid[i] && (fifo_tgt[i] == iw_read_addr2)) begin
                pend2 = 1'b1;
            end
        end
    end

    assign ow_pending1 = pend1;
    assign ow_pending2 = pend2;

    always_ff @(posedge iw_clk) begin
        if (ld_fire) begin
            fifo_tgt[wr_ptr]  <= iw_ld_tgt;
            fifo_data[wr_ptr] <= iw_ld_data;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (ld_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({ld_fire, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Counts consecutive exe wins over a waiting load; saturates to force a pop.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            starve <= '0;
        end else if (fifo_empty || pop) begin
            starve <= '0;
        end else if (exe_fire && (starve != SW'(STARVE_MAX))) begin
            starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            ow_write_enable <= 1'b0;
            ow_write_addr   <= '0;
            ow_write_data   <= '0;
        end else if (exe_fire) begin
            ow_write_enable <= 1'b1;
            ow_write_addr   <= iw_exe_tgt;
            ow_write_data   <= iw_exe_data;
        end else if (pop) begin
            ow_write_enable <= 1'b1;
            ow_write_addr   <= fifo_tgt[rd_ptr];
            ow_write_data   <= fifo_data[rd_ptr];
        end else begin
            ow_write_enable <= 1'b0;
        end
    end

    assign ow_fwd_valid1 = ow_write_enable && (ow_write_addr == iw_read_addr1);
    assign ow_fwd_valid2 = ow_write_enable && (ow_write_addr == iw_read_addr2);
    assign ow_fwd_data1  = ow_write_data;
    assign ow_fwd_data2  = ow_write_data;

endmodule

// File: tb/tb_reggp_wb.sv
// Bench for reggp_wb: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the writeback rules.
module tb_reggp_wb;

    localparam int DW    = 24;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exe_valid;
    logic          exe_ready;
    logic [TW-1:0] exe_tgt;
    logic [DW-1:0] exe_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [TW-1:0] ld_tgt;
    logic [DW-1:0] ld_data;
    logic          write_enable;
    logic [TW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [TW-1:0] read_addr1;
    logic [TW-1:0] read_addr2;
    logic          fwd_valid1;
    logic          fwd_valid2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic          pending1;
    logic          pending2;

    reggp_wb #(.DATA_W(DW), .TGT_W(TW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .iw_clk          (clk),
        .iw_rst_n        (rst_n),
        .iw_exe_valid    (exe_valid),
        .ow_exe_ready    (exe_ready),
        .iw_exe_tgt      (exe_tgt),
        .iw_exe_data     (exe_data),
        .iw_ld_valid     (ld_valid),
        .ow_ld_ready     (ld_ready),
        .iw_ld_tgt       (ld_tgt),
        .iw_ld_data      (ld_data),
        .ow_write_enable (write_enable),
        .ow_write_addr   (write_addr),
        .ow_write_data   (write_data),
        .iw_read_addr1   (read_addr1),
        .iw_read_addr2   (read_addr2),
        .ow_fwd_valid1   (fwd_valid1),
        .ow_fwd_valid2   (fwd_valid2),
        .ow_fwd_data1    (fwd_data1),
        .ow_fwd_data2    (fwd_data2),
        .ow_pending1     (pending1),
        .ow_pending2     (pending2)
    );

    // clock / reset
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // scoreboard: pending loads in acceptance order plus the registered write
    logic [TW-1:0] exp_tgt_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_starve;
    logic          m_we;
    logic [TW-1:0] m_addr;
    logic [DW-1:0] m_data;

    typedef struct {
        logic          ev;
        logic [TW-1:0] et;
        logic [DW-1:0] ed;
        logic          lv;
        logic [TW-1:0] lt;
        logic [DW-1:0] ld;
        logic [TW-1:0] ra1;
        logic [TW-1:0] ra2;
        logic          we;
        logic [TW-1:0] wa;
        logic [DW-1:0] wd;
        logic          erdy;
        logic          lrdy;
        logic          fwd1;
        logic          p1;
        logic          p2;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(int ev, int et, int ed, int lv, int lt, int ld, int ra1, int ra2,
                                int we, int wa, int wd, int erdy, int lrdy, int fwd1, int p1, int p2);
        vec_t v;
        v.ev = ev[0];   v.et = TW'(et);   v.ed = DW'(ed);
        v.lv = lv[0];   v.lt = TW'(lt);   v.ld = DW'(ld);
        v.ra1 = TW'(ra1); v.ra2 = TW'(ra2);
        v.we = we[0];   v.wa = TW'(wa);   v.wd = DW'(wd);
        v.erdy = erdy[0]; v.lrdy = lrdy[0]; v.fwd1 = fwd1[0]; v.p1 = p1[0]; v.p2 = p2[0];
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic m_exe_ready();
        return !((m_starve == SMAX) && (exp_q.size() > 0));
    endfunction

    function automatic logic m_pending(logic [TW-1:0] a);
        foreach (exp_tgt_q[i]) if (exp_tgt_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // driver tasks
    task automatic drive(int r, int ev, int et, int ed, int lv, int lt, int ld, int ra1, int ra2);
        rst_n = r[0];
        exe_valid = ev[0]; exe_tgt = TW'(et); exe_data = DW'(ed);
        ld_valid = lv[0];  ld_tgt = TW'(lt);  ld_data = DW'(ld);
        read_addr1 = TW'(ra1); read_addr2 = TW'(ra2);
    endtask

    // Apply one rising edge to the model using the current inputs, then move the DUT to the next negedge.
    task automatic advance();
        logic efire;
        logic lfire;
        if (!rst_n) begin
            exp_q.delete();
            exp_tgt_q.delete();
            m_starve = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            efire = exe_valid && m_exe_ready();
            lfire = ld_valid && (exp_q.size() < DEPTH);
            if (efire) begin
                m_we = 1'b1; m_addr = exe_tgt; m_data = exe_data;
                if (exp_q.size() > 0) begin
                    if (m_starve < SMAX) m_starve++;
                end else begin
                    m_starve = 0;
                end
            end else if (exp_q.size() > 0) begin
                m_we = 1'b1;
                m_addr = exp_tgt_q.pop_front();
                m_data = exp_q.pop_front();
                m_starve = 0;
            end else begin
                m_we = 1'b0;
                m_starve = 0;
            end
            if (lfire) begin
                exp_tgt_q.push_back(ld_tgt);
                exp_q.push_back(ld_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_compare(string tag);
        logic f1;
        logic f2;
        f1 = m_we && (m_addr == read_addr1);
        f2 = m_we && (m_addr == read_addr2);
        check({tag, "_exe_ready"}, 32'(exe_ready), 32'(m_exe_ready()));
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'(exp_q.size() < DEPTH));
        check({tag, "_we"}, 32'(write_enable), 32'(m_we));
        if (m_we) begin
            check({tag, "_addr"}, 32'(write_addr), 32'(m_addr));
            check({tag, "_data"}, 32'(write_data), 32'(m_data));
        end
        check({tag, "_fwd1"}, 32'(fwd_valid1), 32'(f1));
        check({tag, "_fwd2"}, 32'(fwd_valid2), 32'(f2));
        if (f1) check({tag, "_fwd_data1"}, 32'(fwd_data1), 32'(m_data));
        if (f2) check({tag, "_fwd_data2"}, 32'(fwd_data2), 32'(m_data));
        check({tag, "_pend1"}, 32'(pending1), 32'(m_pending(read_addr1)));
        check({tag, "_pend2"}, 32'(pending2), 32'(m_pending(read_addr2)));
    endtask

    initial begin
        int stall_k;
        int ldw_k;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        advance();
        advance();

        // directed table: forwarding, same-edge exe+load, fill to full, starvation release, drain
        vecs[0]  = mk(1, 3, 'hABCD, 0, 0, 0,      3, 0, 0, 0, 0,        1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,      0, 0, 0,      3, 3, 1, 3, 'hABCD,   1, 1, 1, 0, 0);
        vecs[2]  = mk(1, 4, 'h11,   1, 9, 'h22,   9, 4, 0, 0, 0,        1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,      0, 0, 0,      9, 4, 1, 4, 'h11,     1, 1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0,      0, 0, 0,      9, 4, 1, 9, 'h22,     1, 1, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0,      0, 0, 0,      9, 4, 0, 0, 0,        1, 1, 0, 0, 0);
        vecs[6]  = mk(1, 10, 'h100, 1, 1, 'h201,  1, 2, 0, 0, 0,        1, 1, 0, 0, 0);
        vecs[7]  = mk(1, 11, 'h101, 1, 2, 'h202,  1, 2, 1, 10, 'h100,   1, 1, 0, 1, 0);
        vecs[8]  = mk(1, 12, 'h102, 1, 5, 'h205,  5, 2, 1, 11, 'h101,   1, 1, 0, 0, 1);
        vecs[9]  = mk(1, 13, 'h103, 1, 6, 'h206,  6, 5, 1, 12, 'h102,   1, 1, 0, 0, 1);
        vecs[10] = mk(1, 14, 'h104, 1, 7, 'h207,  7, 6, 1, 13, 'h103,   1, 0, 0, 0, 1);
        vecs[11] = mk(1, 15, 'h105, 1, 7, 'h207,  7, 1, 1, 14, 'h104,   0, 0, 0, 0, 1);
        vecs[12] = mk(1, 15, 'h105, 1, 7, 'h207,  7, 1, 1, 1, 'h201,    1, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0,      0, 0, 0,      7, 2, 1, 15, 'h105,   1, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 0,      0, 0, 0,      2, 5, 1, 2, 'h202,    1, 1, 1, 0, 1);
        vecs[15] = mk(0, 0, 0,      0, 0, 0,      5, 6, 1, 5, 'h205,    1, 1, 1, 0, 1);
        vecs[16] = mk(0, 0, 0,      0, 0, 0,      6, 7, 1, 6, 'h206,    1, 1, 1, 0, 1);
        vecs[17] = mk(0, 0, 0,      0, 0, 0,      7, 7, 1, 7, 'h207,    1, 1, 1, 0, 0);
        vecs[18] = mk(0, 0, 0,      0, 0, 0,      7, 7, 0, 0, 0,        1, 1, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(1, int'(vecs[i].ev), int'(vecs[i].et), int'(vecs[i].ed), int'(vecs[i].lv),
                  int'(vecs[i].lt), int'(vecs[i].ld), int'(vecs[i].ra1), int'(vecs[i].ra2));
            #1;
            check($sformatf("v%0d_we", i), 32'(write_enable), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("v%0d_addr", i), 32'(write_addr), 32'(vecs[i].wa));
                check($sformatf("v%0d_data", i), 32'(write_data), 32'(vecs[i].wd));
            end
            check($sformatf("v%0d_exe_ready", i), 32'(exe_ready), 32'(vecs[i].erdy));
            check($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].lrdy));
            check($sformatf("v%0d_fwd1", i), 32'(fwd_valid1), 32'(vecs[i].fwd1));
            if (vecs[i].fwd1) check($sformatf("v%0d_fwd_data1", i), 32'(fwd_data1), 32'(vecs[i].wd));
            check($sformatf("v%0d_pend1", i), 32'(pending1), 32'(vecs[i].p1));
            check($sformatf("v%0d_pend2", i), 32'(pending2), 32'(vecs[i].p2));
            advance();
        end

        // starvation: one queued load under continuous exe
        drive(1, 1, 1, 'h1, 1, 8, 'h55, 8, 0);
        #1 model_compare("starve_fill");
        advance();
        stall_k = -1;
        ldw_k = -1;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, k + 2, 'h300 + k, 0, 0, 0, 8, 0);
            #1;
            if (!exe_ready && stall_k < 0) stall_k = k;
            if (write_enable && write_addr == 4'd8 && ldw_k < 0) ldw_k = k;
            model_compare($sformatf("starve_k%0d", k));
            advance();
        end
        check("starve_stall_cycle", 32'(stall_k), 32'(4));
        check("starve_load_write_cycle", 32'(ldw_k), 32'(5));

        // reset with three loads queued: none of them may ever be written
        drive(1, 1, 1, 'h10, 1, 3, 'hAA3, 3, 5);
        #1 model_compare("rstq_a");
        advance();
        drive(1, 1, 2, 'h11, 1, 5, 'hAA5, 3, 5);
        #1 model_compare("rstq_b");
        advance();
        drive(1, 1, 4, 'h12, 1, 9, 'hAA9, 3, 9);
        #1 model_compare("rstq_c");
        advance();
        check("rstq_pend_before", 32'(pending1), 32'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 3, 5);
        advance();
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0, (k % 2) ? 9 : 3, 5);
            #1;
            check($sformatf("rstq_we_k%0d", k), 32'(write_enable), 32'(0));
            check($sformatf("rstq_pend1_k%0d", k), 32'(pending1), 32'(0));
            check($sformatf("rstq_pend2_k%0d", k), 32'(pending2), 32'(0));
            check($sformatf("rstq_ld_ready_k%0d", k), 32'(ld_ready), 32'(1));
            advance();
        end

        // reset held two cycles with both sources valid
        drive(0, 1, 6, 'h66, 1, 6, 'h77, 6, 6);
        advance();
        advance();
        drive(1, 1, 6, 'h66, 1, 6, 'h77, 6, 6);
        #1;
        check("rst_we", 32'(write_enable), 32'(0));
        check("rst_ld_ready", 32'(ld_ready), 32'(1));
        check("rst_exe_ready", 32'(exe_ready), 32'(1));
        check("rst_pend1", 32'(pending1), 32'(0));
        check("rst_pend2", 32'(pending2), 32'(0));
        check("rst_fwd1", 32'(fwd_valid1), 32'(0));
        advance();

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 199) == 0) ? 0 : 1,
                  ($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom() & 32'hFFFFFF),
                  ($urandom_range(0, 9) < 5) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom() & 32'hFFFFFF),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            #1 model_compare($sformatf("rnd%0d", n));
            advance();
        end

        // final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
